// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage downstream of execute. Loads and stores go out
//   over a req/gnt/rvalid data bus; the final GPR write is registered here.
//   Load data is byte/half/word extracted and sign/zero extended. While a bus
//   transaction is in flight, stall holds the upstream stage.
//
//   Build option: MEM_MISALIGN_TRAP_EN
//     defined   - misaligned half/word accesses are not issued on the bus;
//                 misalign_o pulses for one cycle instead.
//     undefined - misaligned low address bits are cleared and the access
//                 proceeds as aligned; misalign_o is tied 0.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   stall             combinational hold request to upstream
//   valid_i .. gprs_wdata_i   instruction fields from execute
//   dbus_*            data bus (req held until gnt, rvalid carries load data)
//   gprs_*_o          registered GPR write to the register file
//   misalign_o        one-cycle misaligned-access pulse
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              stall,
  input  logic              valid_i,
  input  logic              mem_rena_i,
  input  logic              mem_wena_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              gprs_wena_i,
  input  logic [REG_W-1:0]  gprs_waddr_i,
  input  logic [DATA_W-1:0] gprs_wdata_i,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [DATA_W-1:0] dbus_addr,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              gprs_wena_o,
  output logic [REG_W-1:0]  gprs_waddr_o,
  output logic [DATA_W-1:0] gprs_wdata_o,
  output logic              misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] op_addr;
  logic [1:0]        op_size;
  logic              op_unsigned;
  logic              op_we;
  logic [REG_W-1:0]  op_waddr;
  logic [DATA_W-1:0] op_wdata;
  logic [3:0]        op_wstrb;

  logic              is_half;
  logic              is_word;
  logic              mem_op;
  logic              start;
  logic              trap;
  logic [DATA_W-1:0] eff_addr;
  logic [DATA_W-1:0] lane_wdata;
  logic [3:0]        lane_wstrb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  assign is_half = (mem_size_i == 2'b01);
  assign is_word = mem_size_i[1];
  assign mem_op  = mem_rena_i | mem_wena_i;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
  assign trap       = valid_i & mem_op & misaligned;
  assign start      = valid_i & mem_op & ~misaligned;
  assign eff_addr   = mem_addr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= (state == IDLE) & trap;
  end
`else
  assign trap       = 1'b0;
  assign start      = valid_i & mem_op;
  assign eff_addr   = {mem_addr_i[DATA_W-1:2],
                       mem_addr_i[1] & ~is_word,
                       mem_addr_i[0] & ~(is_half | is_word)};
  assign misalign_o = 1'b0;
`endif

  // Store data is replicated across lanes so the strobe alone picks the bytes.
  always_comb begin
    lane_wdata = mem_wdata_i;
    lane_wstrb = 4'b1111;
    case (mem_size_i)
      2'b00: begin
        lane_wdata = {4{mem_wdata_i[7:0]}};
        lane_wstrb = 4'b0001 << eff_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{mem_wdata_i[15:0]}};
        lane_wstrb = 4'b0011 << {eff_addr[1], 1'b0};
      end
      default: begin
        lane_wdata = mem_wdata_i;
        lane_wstrb = 4'b1111;
      end
    endcase
    if (!mem_wena_i) lane_wstrb = '0;
  end

  // op_addr[0] is always 0 for halves here, so addr[1] alone selects the lane.
  assign ld_byte = dbus_rdata[{op_addr[1:0], 3'b000} +: 8];
  assign ld_half = dbus_rdata[{op_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (op_size)
      2'b00:   ld_ext = {{(DATA_W-8){~op_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{(DATA_W-16){~op_unsigned & ld_half[15]}}, ld_half};
      default: ld_ext = dbus_rdata;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = start;
      REQ:     stall = ~(op_we & dbus_gnt);
      WAIT:    stall = ~dbus_rvalid;
      default: stall = 1'b0;
    endcase
  end

  assign dbus_req   = (state == REQ);
  assign dbus_we    = op_we;
  assign dbus_addr  = {op_addr[DATA_W-1:2], 2'b00};
  assign dbus_wdata = op_wdata;
  assign dbus_wstrb = op_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_addr      <= '0;
      op_size      <= '0;
      op_unsigned  <= 1'b0;
      op_we        <= 1'b0;
      op_waddr     <= '0;
      op_wdata     <= '0;
      op_wstrb     <= '0;
      gprs_wena_o  <= 1'b0;
      gprs_waddr_o <= '0;
      gprs_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_addr     <= eff_addr;
            op_size     <= mem_size_i;
            op_unsigned <= mem_unsigned_i;
            op_we       <= mem_wena_i;
            op_waddr    <= gprs_waddr_i;
            op_wdata    <= lane_wdata;
            op_wstrb    <= lane_wstrb;
            gprs_wena_o <= 1'b0;
            state       <= REQ;
          end else if (trap) begin
            gprs_wena_o <= 1'b0;
          end else begin
            gprs_wena_o  <= valid_i & gprs_wena_i;
            gprs_waddr_o <= gprs_waddr_i;
            gprs_wdata_o <= gprs_wdata_i;
          end
        end
        REQ: begin
          gprs_wena_o <= 1'b0;
          if (dbus_gnt) state <= op_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (dbus_rvalid) begin
            gprs_wena_o  <= 1'b1;
            gprs_waddr_o <= op_waddr;
            gprs_wdata_o <= ld_ext;
            state        <= IDLE;
          end else begin
            gprs_wena_o <= 1'b0;
          end
        end
        default: begin
          gprs_wena_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Scoreboard bench for mem_stage (default build: misaligned accesses are
//   aligned down). A byte-addressed reference memory predicts bus transfers
//   and load results; a bus responder with its own word memory answers the
//   DUT with random grant/response latency; a monitor pops expectations.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              valid_i;
  logic              mem_rena_i;
  logic              mem_wena_i;
  logic [1:0]        mem_size_i;
  logic              mem_unsigned_i;
  logic [DATA_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              gprs_wena_i;
  logic [REG_W-1:0]  gprs_waddr_i;
  logic [DATA_W-1:0] gprs_wdata_i;
  logic              dbus_req;
  logic              dbus_we;
  logic [DATA_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_wdata;
  logic [3:0]        dbus_wstrb;
  logic              dbus_gnt;
  logic              dbus_rvalid;
  logic [DATA_W-1:0] dbus_rdata;
  logic              gprs_wena_o;
  logic [REG_W-1:0]  gprs_waddr_o;
  logic [DATA_W-1:0] gprs_wdata_o;
  logic              misalign_o;

  mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .valid_i(valid_i), .mem_rena_i(mem_rena_i), .mem_wena_i(mem_wena_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .gprs_wena_i(gprs_wena_i), .gprs_waddr_i(gprs_waddr_i), .gprs_wdata_i(gprs_wdata_i),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .gprs_wena_o(gprs_wena_o), .gprs_waddr_o(gprs_waddr_o), .gprs_wdata_o(gprs_wdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] waddr; logic [31:0] wdata; } gpr_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] data; } bus_t;

  gpr_t        gpr_q[$];
  bus_t        bus_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  ref_mem [1024];  // reference model, byte addressed
  logic [31:0] bmem    [256];   // bus-side memory written only via DUT strobes

  int bstate = 0;
  int lat    = 0;
  int ridx   = 0;
  bit hold_rsp = 1'b0;
  bit stale    = 1'b0;
  bit saw_misalign = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] eff(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = nbytes(sz);
    return a - (a % n);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
    logic [31:0] ea;
    logic [31:0] v;
    logic [9:0]  idx;
    int n;
    ea = eff(a, sz);
    n  = nbytes(sz);
    v  = '0;
    for (int i = 0; i < n; i++) begin
      idx = 10'(ea + i);
      v[i*8 +: 8] = ref_mem[idx];
    end
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic bus_t model_bus(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                     input logic [31:0] d);
    bus_t e;
    logic [31:0] ea;
    int lane;
    ea     = eff(a, sz);
    e.we   = we;
    e.addr = ea - (ea % 4);
    e.strb = '0;
    e.data = '0;
    if (we) begin
      for (int i = 0; i < nbytes(sz); i++) begin
        lane = int'((ea + i) % 4);
        e.strb[lane] = 1'b1;
        e.data[lane*8 +: 8] = d[i*8 +: 8];
      end
    end
    return e;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] ea;
    logic [9:0]  idx;
    ea = eff(a, sz);
    for (int i = 0; i < nbytes(sz); i++) begin
      idx = 10'(ea + i);
      ref_mem[idx] = d[i*8 +: 8];
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    valid_i = 1'b0; mem_rena_i = 1'b0; mem_wena_i = 1'b0; mem_size_i = '0;
    mem_unsigned_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0;
    gprs_wena_i = 1'b0; gprs_waddr_i = '0; gprs_wdata_i = '0;
  endtask

  task automatic alu(input logic v, input logic w, input logic [4:0] wa, input logic [31:0] wd);
    gpr_t g;
    idle_inputs();
    valid_i = v; gprs_wena_i = w; gprs_waddr_i = wa; gprs_wdata_i = wd;
    if (!v) begin
      mem_rena_i = 1'($urandom_range(0, 1));
      mem_wena_i = ~mem_rena_i;
      mem_addr_i = $urandom;
    end
    if (v && w) begin
      g.waddr = wa; g.wdata = wd;
      gpr_q.push_back(g);
    end
    @(negedge clk);
    check("alu_stall", stall, 0);
    @(posedge clk); #1;
  endtask

  task automatic mem_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] wa);
    gpr_t g;
    int waited;
    bus_q.push_back(model_bus(we, a, sz, d));
    if (we) model_store(a, sz, d);
    else begin
      g.waddr = wa; g.wdata = model_load(a, sz, uns);
      gpr_q.push_back(g);
    end
    idle_inputs();
    valid_i = 1'b1; mem_rena_i = ~we; mem_wena_i = we; mem_size_i = sz;
    mem_unsigned_i = uns; mem_addr_i = a; mem_wdata_i = d;
    gprs_wena_i = 1'($urandom_range(0, 1)); gprs_waddr_i = wa; gprs_wdata_i = $urandom;
    @(negedge clk);
    check("mem_stall_start", stall, 1);
    waited = 0;
    while (stall && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (stall) check("mem_op_timeout_stall", stall, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- bus responder ----------------
  initial begin
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
      if (rst) begin
        if (bstate == 1) stale = 1'b1;
        bstate = 0;
      end else if (stale) begin
        dbus_rvalid = 1'b1;            // late response to an op killed by reset
        dbus_rdata  = 32'h8000_00FF;
        stale = 1'b0;
      end else if (bstate == 1) begin
        if (lat == 0 && !hold_rsp) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = bmem[ridx];
          bstate = 0;
        end else if (lat != 0) begin
          lat--;
        end
      end else if (dbus_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dbus_gnt = 1'b1;
          if (dbus_we) begin
            for (int b = 0; b < 4; b++)
              if (dbus_wstrb[b]) bmem[dbus_addr[9:2]][b*8 +: 8] = dbus_wdata[b*8 +: 8];
          end else begin
            bstate = 1;
            ridx   = int'(dbus_addr[9:2]);
            lat    = $urandom_range(0, 3);
          end
        end
      end else if ($urandom_range(0, 5) == 0) begin
        dbus_rvalid = 1'b1;            // stray response, must be ignored
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bus_t e;
    gpr_t g;
    logic [31:0] mask;
    forever begin
      @(negedge clk);
      if (misalign_o) saw_misalign = 1'b1;
      if (!rst && dbus_req && dbus_gnt) begin
        if (bus_q.size() == 0) check("bus_unexpected_req", dbus_req, 0);
        else begin
          e = bus_q.pop_front();
          check("bus_we", dbus_we, e.we);
          check("bus_addr", dbus_addr, e.addr);
          check("bus_wstrb", dbus_wstrb, e.strb);
          if (e.we) begin
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{e.strb[b]}};
            check("bus_wdata", dbus_wdata & mask, e.data);
          end
        end
      end
      if (gprs_wena_o) begin
        if (gpr_q.size() == 0) check("gpr_unexpected_write", gprs_wena_o, 0);
        else begin
          g = gpr_q.pop_front();
          check("gpr_waddr", 32'(gprs_waddr_o), 32'(g.waddr));
          check("gpr_wdata", gprs_wdata_o, g.wdata);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    int r;
    logic [1:0] sz;
    for (int w = 0; w < 256; w++) begin
      bmem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = bmem[w][b*8 +: 8];
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_dbus_req", dbus_req, 0);
    check("rst_stall", stall, 0);
    check("rst_gprs_wena", gprs_wena_o, 0);
    check("rst_gprs_wdata", gprs_wdata_o, 0);
    check("rst_dbus_wstrb", dbus_wstrb, 0);
    check("rst_misalign", misalign_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    alu(1'b1, 1'b1, 5'd5, 32'h1234);                       // pass-through
    alu(1'b0, 1'b1, 5'd6, 32'h5555);                       // bubble: no write
    mem_op(1'b1, 2'd0, 1'b0, 32'h103, 32'hAB, 5'd1);       // store byte, lane 3
    mem_op(1'b1, 2'd2, 1'b0, 32'h200, 32'h8001_0000, 5'd1);
    mem_op(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 5'd9);        // -> FFFF8001
    mem_op(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 5'd10);       // -> 00008001
    mem_op(1'b0, 2'd2, 1'b0, 32'h301, 32'h0, 5'd11);       // aligned down to 0x300
    mem_op(1'b0, 2'd3, 1'b0, 32'h302, 32'h0, 5'd12);       // size 11 as word
    mem_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd13);       // load back stored byte
    alu(1'b1, 1'b1, 5'd7, 32'hBEEF);                       // right behind a load

    // Reset while a load waits for its response.
    hold_rsp = 1'b1;
    bus_q.push_back(model_bus(1'b0, 32'h104, 2'd2, 32'h0));
    idle_inputs();
    valid_i = 1'b1; mem_rena_i = 1'b1; mem_size_i = 2'd2; mem_addr_i = 32'h104;
    gprs_waddr_i = 5'd20;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bstate != 1 && waited < 60);
    if (bstate != 1) check("rst_test_grant_timeout", dbus_req, 0);
    @(posedge clk); #3;
    check("wait_stall", stall, 1);
    rst = 1'b1; valid_i = 1'b0; mem_rena_i = 1'b0;
    #1;
    check("midrst_dbus_req", dbus_req, 0);
    check("midrst_stall", stall, 0);
    check("midrst_gprs_wena", gprs_wena_o, 0);
    check("midrst_gprs_wdata", gprs_wdata_o, 0);
    check("midrst_gprs_waddr", 32'(gprs_waddr_o), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    hold_rsp = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      if (r < 4)
        alu(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
            5'($urandom), $urandom);
      else
        mem_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               32'h100 + 32'($urandom_range(0, 32'h2FC)), $urandom, 5'($urandom));
    end

    idle_inputs();
    repeat (5) @(posedge clk);
    #1;
    check("gpr_queue_drained", gpr_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    check("misalign_never", 32'(saw_misalign), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
